pipelined_addsub: RTL

//  Parametrised, pipelined WIDTH-bit adder/subtractor built from full-adder slices.
//  The operand is split into STAGES equal chunks, and one chunk's ripple-carry is resolved per clock.

---
 rtl/pipelined_addsub.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit ripple-carry chunk is resolved per stage,
// with a valid/ready handshake on each side and a single advance enable shared by every stage.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CW = WIDTH / STAGES;

    // Full-adder ripple over one chunk; returns {carry out, carry into MSB, sum}.
    function automatic logic [CW+1:0] chunk_add(input logic [CW-1:0] a,
                                                input logic [CW-1:0] b,
                                                input logic          ci);
        logic          c;
        logic          cm;
        logic [CW-1:0] s;
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < CW; i++) begin
            cm   = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, cm, s};
    endfunction

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic [WIDTH-1:0] w_a   [STAGES];
    logic [WIDTH-1:0] w_b   [STAGES];
    logic [WIDTH-1:0] w_sp  [STAGES];
    logic [WIDTH-1:0] w_sn  [STAGES];
    logic             w_ci  [STAGES];
    logic             w_vi  [STAGES];
    logic [CW+1:0]    w_add [STAGES];
    logic             w_adv;

    assign w_adv     = !r_v[STAGES-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES-1];
    assign out_sum   = r_sum[STAGES-1];
    assign out_cout  = r_c[STAGES-1];
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

    // Stage operand sources and per-stage chunk addition.
    always_comb begin
        // Stage 0 takes the raw beat; subtraction becomes A + ~B + 1 here so later stages only add.
        w_a[0]  = in_a;
        w_b[0]  = in_sub ? ~in_b : in_b;
        w_ci[0] = in_sub ? 1'b1 : in_cin;
        w_sp[0] = '0;
        w_vi[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a[k]  = r_a[k-1];
            w_b[k]  = r_b[k-1];
            w_ci[k] = r_c[k-1];
            w_sp[k] = r_sum[k-1];
            w_vi[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_add[k]              = chunk_add(w_a[k][k*CW +: CW], w_b[k][k*CW +: CW], w_ci[k]);
            w_sn[k]               = w_sp[k];
            w_sn[k][k*CW +: CW]   = w_add[k][CW-1:0];
        end
    end

    // Pipeline registers: every stage shifts together on advance, otherwise all hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a[k];
                r_b[k]   <= w_b[k];
                r_sum[k] <= w_sn[k];
                r_c[k]   <= w_add[k][CW+1];
                r_v[k]   <= w_vi[k];
            end
            r_ovf  <= w_add[STAGES-1][CW+1] ^ w_add[STAGES-1][CW];
            r_zero <= (w_sn[STAGES-1] == {WIDTH{1'b0}});
        end
    end

endmodule
